// File: rtl/o2adder_pipe_pkg.sv
// Shared definitions for the o2adder pipeline: operation mode encodings, the default data
// width and the legal range of the pipeline depth.
package o2adder_pipe_pkg;

   typedef enum logic [1:0] {
      ModePass  = 2'b00,  // aout = ain, bout = bin
      ModeBoth  = 2'b01,  // aout = sum, bout = sum
      ModeLeft  = 2'b10,  // aout = sum, bout = bin
      ModeRight = 2'b11   // aout = ain, bout = sum
   } mode_e;

   localparam int unsigned DwDefault = 32;
   localparam int unsigned LatMin    = 1;
   localparam int unsigned LatMax    = 4;

endpackage

// File: rtl/fp32adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormal inputs are treated as zero and subnormal results flush to signed zero.
// NaN inputs or inf + (-inf) give the canonical quiet NaN 0x7fc00000.
// Ports:
//   a, b : operands
//   sum  : a + b
module fp32adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   logic              a_nan, b_nan, a_inf, b_inf;
   logic              swap, sub, sl, ss;
   logic [7:0]        el, es, d;
   logic [23:0]       ml, ms;
   logic [49:0]       ms_w;
   logic [26:0]       ml_x, ms_x, norm;
   logic [27:0]       raw;
   logic [4:0]        lz;
   logic [24:0]       rnd;
   logic signed [9:0] exp_n, exp_r;
   logic              unused_hidden;

   always_comb begin
      a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);

      // Order by magnitude so the larger operand sets exponent and sign.
      swap = b[30:0] > a[30:0];
      sl   = swap ? b[31] : a[31];
      ss   = swap ? a[31] : b[31];
      el   = swap ? b[30:23] : a[30:23];
      es   = swap ? a[30:23] : b[30:23];
      ml   = (el == 8'd0) ? 24'd0 : {1'b1, (swap ? b[22:0] : a[22:0])};
      ms   = (es == 8'd0) ? 24'd0 : {1'b1, (swap ? a[22:0] : b[22:0])};
      sub  = sl ^ ss;
      d    = el - es;

      // Align: mantissa plus guard, round and sticky bits.
      ms_w = {ms, 26'd0} >> d;
      ml_x = {ml, 3'd0};
      ms_x = {ms_w[49:24], (|ms_w[23:0]) | ((d > 8'd26) && (ms != 24'd0))};
      raw  = sub ? ({1'b0, ml_x} - {1'b0, ms_x}) : ({1'b0, ml_x} + {1'b0, ms_x});

      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (raw[i]) lz = 5'(26 - i);
      end

      if (raw[27]) begin
         norm  = {raw[27:2], raw[1] | raw[0]};
         exp_n = $signed({2'b00, el}) + 10'sd1;
      end else begin
         norm  = raw[26:0] << lz;
         exp_n = $signed({2'b00, el}) - $signed({5'd0, lz});
      end

      rnd   = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
      // Rounding carry out of the mantissa leaves the fraction at zero and bumps the exponent.
      exp_r = exp_n + $signed({9'd0, rnd[24]});

      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
         sum = 32'h7fc0_0000;
      end else if (a_inf) begin
         sum = {a[31], 8'hff, 23'd0};
      end else if (b_inf) begin
         sum = {b[31], 8'hff, 23'd0};
      end else if (raw == 28'd0) begin
         sum = {sl & ~sub, 31'd0};
      end else if (exp_r >= 10'sd255) begin
         sum = {sl, 8'hff, 23'd0};
      end else if (exp_r <= 10'sd0) begin
         sum = {sl, 31'd0};
      end else begin
         sum = {sl, exp_r[7:0], rnd[22:0]};
      end
   end

   assign unused_hidden = rnd[23];

endmodule

// File: rtl/o2_pipe_stage.sv
// One pipeline stage: a valid flag plus two data words.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   en                 : shift enable (load from the inputs)
//   clr                : synchronous clear of the valid flag, wins over en
//   in_valid/in_a/in_b : stage inputs
//   out_valid/out_a/out_b : registered stage contents
module o2_pipe_stage #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   output logic          out_valid,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b
);

   logic          valid_q;
   logic [DW-1:0] a_q, b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         if (clr) begin
            valid_q <= 1'b0;
         end else if (en) begin
            valid_q <= in_valid;
         end
         // Data may go stale under clr; only the valid flag matters then.
         if (en) begin
            a_q <= in_a;
            b_q <= in_b;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_a     = a_q;
   assign out_b     = b_q;

endmodule

// File: rtl/o2adder_pipe.sv
// FP32 operand-pair pipeline: computes ain + bin on the input side, selects the output pair
// by mode, and carries it through LAT stages with a valid/ready handshake at both ends.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr                   : synchronous flush of every stage
//   in_valid/in_ready     : input handshake; ain, bin, mode sampled on acceptance
//   out_valid/out_ready   : output handshake; aout, bout hold the result
module o2adder_pipe
   import o2adder_pipe_pkg::*;
#(
   parameter int unsigned LAT = 2,          // register stages, 1..4
   parameter int unsigned DW  = DwDefault   // FP32 only
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] ain,
   input  logic [DW-1:0] bin,
   input  logic [1:0]    mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] aout,
   output logic [DW-1:0] bout
);

   logic          advance;
   logic [DW-1:0] sum, a_sel, b_sel;
   logic          stg_v [LAT];
   logic [DW-1:0] stg_a [LAT];
   logic [DW-1:0] stg_b [LAT];

   // The whole pipe moves together; bubbles are never squeezed out during a stall.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !clr;

   fp32adder u_fp32adder (
      .a  (ain),
      .b  (bin),
      .sum(sum)
   );

   always_comb begin
      a_sel = ain;
      b_sel = bin;
      unique case (mode_e'(mode))
         ModePass:  ;
         ModeBoth:  begin a_sel = sum; b_sel = sum; end
         ModeLeft:  a_sel = sum;
         ModeRight: b_sel = sum;
      endcase
   end

   for (genvar i = 0; i < LAT; i++) begin : g_stage
      logic          v_in;
      logic [DW-1:0] a_in, b_in;

      if (i == 0) begin : g_first
         assign v_in = in_valid && in_ready;
         assign a_in = a_sel;
         assign b_in = b_sel;
      end else begin : g_next
         assign v_in = stg_v[i-1];
         assign a_in = stg_a[i-1];
         assign b_in = stg_b[i-1];
      end

      o2_pipe_stage #(
         .DW(DW)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (advance),
         .clr      (clr),
         .in_valid (v_in),
         .in_a     (a_in),
         .in_b     (b_in),
         .out_valid(stg_v[i]),
         .out_a    (stg_a[i]),
         .out_b    (stg_b[i])
      );
   end

   assign out_valid = stg_v[LAT-1];
   assign aout      = stg_a[LAT-1];
   assign bout      = stg_b[LAT-1];

endmodule

// File: tb/tb_o2adder_pipe.sv
// Bench for o2adder_pipe: directed vectors and corner sequences on a LAT=2 instance, then
// random traffic on LAT=1/2/4 instances against a real-arithmetic reference model.
module tb_o2adder_pipe;
   import o2adder_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, clr, in_valid, out_ready;
   logic [31:0] ain, bin;
   logic [1:0]  mode;
   logic        ir1, ir2, ir4, ov1, ov2, ov4;
   logic [31:0] oa1, ob1, oa2, ob2, oa4, ob4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   o2adder_pipe #(.LAT(1), .DW(32)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
      .ain(ain), .bin(bin), .mode(mode), .out_valid(ov1), .out_ready(out_ready),
      .aout(oa1), .bout(ob1));
   o2adder_pipe #(.LAT(2), .DW(32)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir2),
      .ain(ain), .bin(bin), .mode(mode), .out_valid(ov2), .out_ready(out_ready),
      .aout(oa2), .bout(ob2));
   o2adder_pipe #(.LAT(4), .DW(32)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir4),
      .ain(ain), .bin(bin), .mode(mode), .out_valid(ov4), .out_ready(out_ready),
      .aout(oa4), .bout(ob4));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: exact sum in double precision, then rounded to single (RNE).
   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e11;
      if (f[30:23] == 8'd0) return 0.0;
      e11 = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e11, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [30:0] mag;
      logic        up;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      mag = {8'(d[62:52] - 11'd896), d[51:29]};
      up  = d[28] && ((d[27:0] != 28'd0) || d[29]);
      return {d[63], mag + {30'd0, up}};
   endfunction

   function automatic logic [63:0] ref_pair(input logic [1:0] m, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] s;
      s = r2f(f2r(a) + f2r(b));
      case (m)
         2'b00:   return {a, b};
         2'b01:   return {s, s};
         2'b10:   return {s, b};
         default: return {a, s};
      endcase
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b);
      in_valid = v;
      mode     = m;
      ain      = a;
      bin      = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 drive(1'b0, 2'b00, 32'd0, 32'd0);
      end
   endtask

   // Scoreboard for the random phase, one queue per instance (LAT 1, 2, 4).
   typedef struct {
      logic [63:0] res;
      int          acc;
   } sb_t;
   sb_t         sbq [3][$];
   int          lat_of [3] = '{1, 2, 4};
   int          min_lat [3] = '{99, 99, 99};
   logic        hold_v [3] = '{1'b0, 1'b0, 1'b0};
   logic [63:0] hold_d [3];
   logic        sb_on = 1'b0;

   always @(negedge clk) begin
      if (sb_on) begin
         logic        irk [3];
         logic        ovk [3];
         logic [63:0] odk [3];
         sb_t         e;
         irk = '{ir1, ir2, ir4};
         ovk = '{ov1, ov2, ov4};
         odk = '{{oa1, ob1}, {oa2, ob2}, {oa4, ob4}};
         for (int k = 0; k < 3; k++) begin
            if (hold_v[k]) begin
               check($sformatf("stall_hold_v%0d", k), {63'd0, ovk[k]}, 64'd1);
               check($sformatf("stall_hold_d%0d", k), odk[k], hold_d[k]);
            end
            if (ovk[k] && out_ready) begin
               if (sbq[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_extra%0d: got %h expected no result", k, odk[k]);
               end else begin
                  e = sbq[k].pop_front();
                  check($sformatf("sb_data%0d", k), odk[k], e.res);
                  check($sformatf("sb_lat_min%0d", k), {63'd0, (cyc - e.acc) >= lat_of[k]},
                        64'd1);
                  if ((cyc - e.acc) < min_lat[k]) min_lat[k] <= cyc - e.acc;
               end
            end
            if (in_valid && irk[k]) sbq[k].push_back('{ref_pair(mode, ain, bin), cyc});
            hold_v[k] <= ovk[k] && !out_ready;
            hold_d[k] <= odk[k];
         end
      end
   end

   typedef struct {
      logic [1:0]  m;
      logic [31:0] a, b, ea, eb;
   } vec_t;
   vec_t tab [13];

   initial begin
      logic [31:0] held_a, held_b;
      int          sent, rcv;

      tab[0]  = '{2'b01, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40400000};
      tab[1]  = '{2'b00, 32'h3f800000, 32'h40000000, 32'h3f800000, 32'h40000000};
      tab[2]  = '{2'b10, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40000000};
      tab[3]  = '{2'b11, 32'h3f800000, 32'h40000000, 32'h3f800000, 32'h40400000};
      tab[4]  = '{2'b01, 32'h3fc00000, 32'hbfc00000, 32'h00000000, 32'h00000000};
      tab[5]  = '{2'b10, 32'h3f800000, 32'h33800000, 32'h3f800000, 32'h33800000};
      tab[6]  = '{2'b11, 32'h3f800000, 32'h34000000, 32'h3f800000, 32'h3f800001};
      tab[7]  = '{2'b01, 32'h7f800000, 32'h3f800000, 32'h7f800000, 32'h7f800000};
      tab[8]  = '{2'b10, 32'h7f800000, 32'hff800000, 32'h7fc00000, 32'hff800000};
      tab[9]  = '{2'b11, 32'hc0400000, 32'h3f800000, 32'hc0400000, 32'hc0000000};
      tab[10] = '{2'b01, 32'h7f7fffff, 32'h7f7fffff, 32'h7f800000, 32'h7f800000};
      tab[11] = '{2'b00, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
      tab[12] = '{2'b01, 32'h40000000, 32'h40000000, 32'h40800000, 32'h40800000};

      // Reset state, checked before any clock edge.
      rst_n = 1'b0;
      clr = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 2'b00, 32'd0, 32'd0);
      #3;
      check("reset_out_valid", {63'd0, ov2}, 64'd0);
      check("reset_data", {oa2, ob2}, 64'd0);
      #9 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", {63'd0, ir2}, 64'd1);

      // Table vectors back-to-back; each result appears exactly two edges after acceptance.
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (i < 13) drive(1'b1, tab[i].m, tab[i].a, tab[i].b);
         else drive(1'b0, 2'b00, 32'd0, 32'd0);
         @(negedge clk);
         if (i >= 2) begin
            check($sformatf("vec%0d_valid", i - 2), {63'd0, ov2}, 64'd1);
            check($sformatf("vec%0d_data", i - 2), {oa2, ob2}, {tab[i-2].ea, tab[i-2].eb});
         end else begin
            check($sformatf("early_valid%0d", i), {63'd0, ov2}, 64'd0);
         end
      end
      idle(3);

      // Stall: fill the pipe, hold out_ready low for 5 cycles, then drain in order.
      sent = 0;
      rcv  = 0;
      for (int s = 0; s < 25; s++) begin
         @(posedge clk);
         #1;
         out_ready = !(s >= 4 && s < 9);
         drive(sent < 8, 2'b00, 32'h100 + 32'(sent), ~(32'h100 + 32'(sent)));
         @(negedge clk);
         if (s == 4) begin
            held_a = oa2;
            held_b = ob2;
            check("stall_full", {63'd0, ov2}, 64'd1);
         end
         if (s >= 4 && s < 9) begin
            check($sformatf("stall_in_ready%0d", s), {63'd0, ir2}, 64'd0);
            check($sformatf("stall_data%0d", s), {oa2, ob2}, {held_a, held_b});
         end
         if (ov2 && out_ready) begin
            check($sformatf("stall_order%0d", rcv), {oa2, ob2},
                  {32'h100 + 32'(rcv), ~(32'h100 + 32'(rcv))});
            rcv++;
         end
         if (in_valid && ir2) sent++;
      end
      check("stall_count", 64'(rcv), 64'd8);
      out_ready = 1'b1;
      idle(2);

      // Flush with two pairs in flight and a third offered alongside clr.
      for (int s = 0; s < 3; s++) begin
         @(posedge clk);
         #1 drive(1'b1, 2'b01, 32'h3f800000, 32'h3f800000);
         clr = (s == 2);
         @(negedge clk);
         if (s == 2) begin
            check("clr_pending_valid", {63'd0, ov2}, 64'd1);
            check("clr_in_ready", {63'd0, ir2}, 64'd0);
         end
      end
      @(posedge clk);
      #1 clr = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0);
      @(negedge clk);
      check("clr_out_valid", {63'd0, ov2}, 64'd0);
      check("clr_in_ready_after", {63'd0, ir2}, 64'd1);
      begin
         int seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (ov2) seen++;
         end
         check("clr_no_leak", 64'(seen), 64'd0);
      end

      // Asynchronous reset mid-stream.
      for (int s = 0; s < 3; s++) begin
         @(posedge clk);
         #1 drive(1'b1, 2'b01, 32'h3f800000, 32'h40000000);
      end
      @(negedge clk);
      check("pre_reset_valid", {63'd0, ov2}, 64'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      check("async_reset_valid", {63'd0, ov2}, 64'd0);
      check("async_reset_data", {oa2, ob2}, 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 drive(1'b1, 2'b01, 32'h40400000, 32'h3f800000);
      @(posedge clk);
      #1 drive(1'b0, 2'b00, 32'd0, 32'd0);
      @(negedge clk);
      check("post_reset_early", {63'd0, ov2}, 64'd0);
      @(negedge clk);
      check("post_reset_valid", {63'd0, ov2}, 64'd1);
      check("post_reset_data", {oa2, ob2}, {32'h40800000, 32'h40800000});
      idle(6);

      // Random traffic on all three depths.
      @(posedge clk);
      #1 sb_on = 1'b1;
      repeat (600) begin
         drive($urandom_range(0, 3) != 0, 2'($urandom), rand_fp(), rand_fp());
         out_ready = $urandom_range(0, 3) != 0;
         @(posedge clk);
         #1;
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0);
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 sb_on = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("sb_drained%0d", k), 64'(sbq[k].size()), 64'd0);
         check($sformatf("sb_latency%0d", k), 64'(min_lat[k]), 64'(lat_of[k]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/o2adder_pipe.md
O2ADDER_PIPE -- requirements
Module: o2adder_pipe

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the number of register stages from input to output; legal range 1..4.
REQ-002 SHALL have parameter DW, default 32, meaning the data word width; only 32 (FP32) is supported.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 clr  input  1  synchronous flush; invalidates all pipeline stages.
REQ-006 in_valid  input  1  input operand pair is valid.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 ain, bin  input  DW each  FP32 operands.
REQ-009 mode  input  2  operation select, sampled with the operands.
REQ-010 out_valid  output  1  aout/bout hold a result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 aout, bout  output  DW each  result words.

Function
REQ-013 SHALL compute sum = ain + bin (FP32) combinationally on the input side, in the same cycle as acceptance.
REQ-014 mode 00 (PASS): aout = ain, bout = bin.
REQ-015 mode 01 (BOTH): aout = sum, bout = sum.
REQ-016 mode 10 (LEFT): aout = sum, bout = bin.
REQ-017 mode 11 (RIGHT): aout = ain, bout = sum.
REQ-018 An input pair is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance && !clr.
REQ-020 On advance, every stage SHALL shift by one; the first stage SHALL load the mode-selected pair with valid = in_valid && in_ready.
REQ-021 When advance = 0, all stages (data and valid) SHALL hold; aout/bout SHALL be stable while out_valid && !out_ready.
REQ-022 Latency SHALL be exactly LAT cycles from acceptance to out_valid when out_ready is held high; throughput SHALL be 1 pair per cycle.
REQ-023 Bubbles (stages with valid = 0) SHALL shift through normally and SHALL NOT be compressed while stalled.
REQ-024 Results SHALL leave in acceptance order; nothing is dropped or duplicated.
REQ-025 clr SHALL clear every stage valid on the next edge, overriding advance and in_valid; data registers may keep stale values.
REQ-026 clr asserted together with a pending output SHALL discard that result without a handshake.
REQ-027 mode SHALL be carried per pair; a mode change between consecutive pairs SHALL take effect with no bubble.

Reset
REQ-028 On rst_n low, asynchronously: all stage valids = 0, out_valid = 0, aout = 0, bout = 0, and all internal data registers = 0.
REQ-029 in_ready SHALL be 1 during the first cycle after reset release, provided clr = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight pairs.

Structure
REQ-031 A shared package SHALL hold the mode encodings (PASS, BOTH, LEFT, RIGHT), the DW default and the LAT limits.
REQ-032 SHALL instantiate the team's existing combinational fp32adder for the sum.
REQ-033 SHALL use one sub-module, o2_pipe_stage (valid plus two data words, with enable and clear), instantiated LAT times through a generate loop.

Verification
REQ-034 LAT=2, out_ready=1, mode=01, ain=0x3F800000, bin=0x40000000 -> exactly 2 cycles later out_valid=1, aout=bout=0x40400000.
REQ-035 mode sequence 00,10,11 on back-to-back cycles, ain=0x3F800000, bin=0x40000000 -> outputs (0x3F800000,0x40000000), (0x40400000,0x40000000), (0x3F800000,0x40400000) on consecutive cycles.
REQ-036 Fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0, aout/bout unchanged; after out_ready=1, results arrive in order with no loss.
REQ-037 Assert clr for 1 cycle with LAT pairs in flight -> next cycle out_valid=0 and in_ready=1; no flushed pair ever appears at the output.
REQ-038 Pull rst_n low mid-stream between clock edges -> out_valid, aout, bout go to 0 immediately; after release, a new pair gives the correct result after LAT cycles.
REQ-039 Sweep LAT = 1 and LAT = 4 with random valid/ready -> a scoreboard matches every result and the measured latency equals LAT.
